// File: rtl/cluster_head_selector.sv
// Cluster-head table with a sequential fewest-hops / highest-Q selector.
// Optional build macro KCH_REPLACE_EN: a new ID arriving while full may evict the worst-hop slot.
module cluster_head_selector #(
    parameter int DEPTH = 16,
    parameter int ID_W  = 16,
    parameter int Q_W   = 16,
    parameter int HOP_W = 16
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       wr_en,
    input  logic [ID_W-1:0]            wr_id,
    input  logic [Q_W-1:0]             wr_qvalue,
    input  logic [HOP_W-1:0]           wr_hops,
    output logic                       wr_ready,
    input  logic                       clear,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       found,
    output logic [ID_W-1:0]            chosen_ch,
    output logic [HOP_W-1:0]           chosen_hops,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       overflow
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t             state_q;
    logic [ID_W-1:0]    id_q   [DEPTH];
    logic [Q_W-1:0]     qv_q   [DEPTH];
    logic [HOP_W-1:0]   hops_q [DEPTH];
    logic [IDX_W-1:0]   idx_q;
    logic               best_valid_q;
    logic [ID_W-1:0]    best_id_q;
    logic [Q_W-1:0]     best_q_q;
    logic [HOP_W-1:0]   best_hops_q;
    logic               busy_q, done_q, found_q, overflow_q;
    logic [ID_W-1:0]    chosen_ch_q;
    logic [HOP_W-1:0]   chosen_hops_q;
    logic [CNT_W-1:0]   count_q;

    logic               wr_accept;
    logic               match_hit, free_hit, cand_better;
    logic [IDX_W-1:0]   match_idx, free_idx;
`ifdef KCH_REPLACE_EN
    logic [IDX_W-1:0]   repl_idx;
    logic [HOP_W-1:0]   repl_hops;
    logic               repl_ok;
`endif

    assign wr_accept   = wr_en && !busy_q && (wr_id != '0) && !clear;
    assign wr_ready    = !busy_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign found       = found_q;
    assign chosen_ch   = chosen_ch_q;
    assign chosen_hops = chosen_hops_q;
    assign count       = count_q;
    assign full        = (count_q == CNT_W'(DEPTH));
    assign overflow    = overflow_q;

    // Lowest-index match and lowest-index free slot for the incoming write.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!match_hit && id_q[i] == wr_id) begin
                match_hit = 1'b1;
                match_idx = IDX_W'(i);
            end
            if (!free_hit && id_q[i] == '0) begin
                free_hit = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

`ifdef KCH_REPLACE_EN
    // Only consulted when full, so every slot is occupied; strict > keeps the lowest index on ties.
    always_comb begin
        repl_idx  = '0;
        repl_hops = hops_q[0];
        for (int i = 1; i < DEPTH; i++) begin
            if (hops_q[i] > repl_hops) begin
                repl_hops = hops_q[i];
                repl_idx  = IDX_W'(i);
            end
        end
        repl_ok = (wr_hops < repl_hops);
    end
`endif

    assign cand_better = (id_q[idx_q] != '0) &&
                         (!best_valid_q || (hops_q[idx_q] < best_hops_q) ||
                          ((hops_q[idx_q] == best_hops_q) && (qv_q[idx_q] > best_q_q)));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                id_q[i]   <= '0;
                qv_q[i]   <= '0;
                hops_q[i] <= '0;
            end
            idx_q         <= '0;
            best_valid_q  <= 1'b0;
            best_id_q     <= '0;
            best_q_q      <= '0;
            best_hops_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            found_q       <= 1'b0;
            overflow_q    <= 1'b0;
            chosen_ch_q   <= '0;
            chosen_hops_q <= '0;
            count_q       <= '0;
        end else begin
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            if (clear) begin
                // Flush aborts any scan silently; chosen_* keep their last values.
                for (int i = 0; i < DEPTH; i++) id_q[i] <= '0;
                count_q <= '0;
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                if (wr_accept) begin
                    if (match_hit) begin
                        qv_q[match_idx]   <= wr_qvalue;
                        hops_q[match_idx] <= wr_hops;
                    end else if (free_hit) begin
                        id_q[free_idx]   <= wr_id;
                        qv_q[free_idx]   <= wr_qvalue;
                        hops_q[free_idx] <= wr_hops;
                        count_q          <= count_q + CNT_W'(1);
                    end else begin
`ifdef KCH_REPLACE_EN
                        if (repl_ok) begin
                            id_q[repl_idx]   <= wr_id;
                            qv_q[repl_idx]   <= wr_qvalue;
                            hops_q[repl_idx] <= wr_hops;
                        end else begin
                            overflow_q <= 1'b1;
                        end
`else
                        overflow_q <= 1'b1;
`endif
                    end
                end
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q      <= S_SCAN;
                            busy_q       <= 1'b1;
                            idx_q        <= '0;
                            best_valid_q <= 1'b0;
                            best_id_q    <= '0;
                            best_q_q     <= '0;
                            best_hops_q  <= '0;
                        end
                    end
                    S_SCAN: begin
                        if (cand_better) begin
                            best_valid_q <= 1'b1;
                            best_id_q    <= id_q[idx_q];
                            best_q_q     <= qv_q[idx_q];
                            best_hops_q  <= hops_q[idx_q];
                        end
                        if (idx_q == IDX_W'(DEPTH-1)) state_q <= S_DONE;
                        else                          idx_q   <= idx_q + IDX_W'(1);
                    end
                    S_DONE: begin
                        chosen_ch_q   <= best_id_q;
                        chosen_hops_q <= best_hops_q;
                        found_q       <= best_valid_q;
                        done_q        <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cluster_head_selector.sv
// Directed table-driven bench for cluster_head_selector (DEPTH=16), plus scan abort sequences.
module tb_cluster_head_selector;
    logic        clk = 1'b0;
    logic        nrst;
    logic        wr_en;
    logic [15:0] wr_id, wr_qvalue, wr_hops;
    logic        wr_ready, clear, start, busy, done, found, full, overflow;
    logic [15:0] chosen_ch, chosen_hops;
    logic [4:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    localparam int OP_IDLE = 0, OP_WR = 1, OP_CLR = 2, OP_WRCLR = 3, OP_SCAN = 4;

    typedef struct {
        int          kind;
        logic [15:0] id, q, hops;
        logic [4:0]  exp_count;
        logic        exp_full, exp_ovf, exp_found;
        logic [15:0] exp_ch, exp_hops;
    } vec_t;

    vec_t vec_q[$];

    cluster_head_selector dut (
        .clk(clk), .nrst(nrst), .wr_en(wr_en), .wr_id(wr_id), .wr_qvalue(wr_qvalue),
        .wr_hops(wr_hops), .wr_ready(wr_ready), .clear(clear), .start(start), .busy(busy),
        .done(done), .found(found), .chosen_ch(chosen_ch), .chosen_hops(chosen_hops),
        .count(count), .full(full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic add(input int k, input logic [15:0] id, input logic [15:0] q,
                       input logic [15:0] hops, input logic [4:0] cnt, input logic fl,
                       input logic ovf, input logic ef, input logic [15:0] ech,
                       input logic [15:0] eh);
        vec_t v;
        v.kind = k; v.id = id; v.q = q; v.hops = hops; v.exp_count = cnt; v.exp_full = fl;
        v.exp_ovf = ovf; v.exp_found = ef; v.exp_ch = ech; v.exp_hops = eh;
        vec_q.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_scan(input logic ef, input logic [15:0] ech, input logic [15:0] eh,
                           input logic [4:0] ecnt);
        int  n;
        bit  seen;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_rise", 32'(busy), 32'd1);
        chk("wr_ready_busy", 32'(wr_ready), 32'd0);
        n = 0;
        seen = 0;
        while (n < 40 && !seen) begin
            tick();
            n++;
            if (done) seen = 1;
        end
        chk("scan_latency", seen ? 32'(n) : 32'd999, 32'd17);
        chk("found", 32'(found), 32'(ef));
        chk("chosen_ch", 32'(chosen_ch), 32'(ech));
        chk("chosen_hops", 32'(chosen_hops), 32'(eh));
        chk("scan_count", 32'(count), 32'(ecnt));
        chk("busy_end", 32'(busy), 32'd0);
        tick();
        chk("done_pulse_len", 32'(done), 32'd0);
        chk("chosen_hold", 32'(chosen_ch), 32'(ech));
    endtask

    initial begin
        logic [15:0] last_ch, last_hops;
        bit          saw_done;

        nrst = 1'b0; wr_en = 1'b0; wr_id = '0; wr_qvalue = '0; wr_hops = '0;
        clear = 1'b0; start = 1'b0;

        // Vector table
        add(OP_WR,   16'h0001, 16'h00C0, 16'd2, 5'd1, 0, 0, 0, 0, 0);
        add(OP_WR,   16'h0002, 16'h00F0, 16'd3, 5'd2, 0, 0, 0, 0, 0);
        add(OP_WR,   16'h0003, 16'h00E6, 16'd2, 5'd3, 0, 0, 0, 0, 0);
        add(OP_SCAN, 0, 0, 0, 5'd3, 0, 0, 1, 16'h0003, 16'd2);
        add(OP_WR,   16'h0000, 16'h0011, 16'd1, 5'd3, 0, 0, 0, 0, 0);
        add(OP_WRCLR,16'h0009, 16'h0011, 16'd1, 5'd0, 0, 0, 0, 0, 0);
        add(OP_WR,   16'h0005, 16'h0010, 16'd4, 5'd1, 0, 0, 0, 0, 0);
        add(OP_WR,   16'h0005, 16'h0020, 16'd1, 5'd1, 0, 0, 0, 0, 0);
        add(OP_SCAN, 0, 0, 0, 5'd1, 0, 0, 1, 16'h0005, 16'd1);
        add(OP_CLR,  0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
        add(OP_WR,   16'h0010, 16'h0080, 16'd2, 5'd1, 0, 0, 0, 0, 0);
        add(OP_WR,   16'h0011, 16'h0080, 16'd2, 5'd2, 0, 0, 0, 0, 0);
        add(OP_SCAN, 0, 0, 0, 5'd2, 0, 0, 1, 16'h0010, 16'd2);
        add(OP_CLR,  0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
        add(OP_SCAN, 0, 0, 0, 5'd0, 0, 0, 0, 16'h0000, 16'd0);
        for (int i = 0; i < 16; i++)
            add(OP_WR, 16'(16'h0020 + i), 16'(i), 16'd5, 5'(i + 1), (i == 15), 0, 0, 0, 0);
`ifdef KCH_REPLACE_EN
        add(OP_WR,   16'h00AA, 16'h0050, 16'd1, 5'd16, 1, 0, 0, 0, 0);
`else
        add(OP_WR,   16'h00AA, 16'h0050, 16'd1, 5'd16, 1, 1, 0, 0, 0);
`endif
        add(OP_IDLE, 0, 0, 0, 5'd16, 1, 0, 0, 0, 0);
        add(OP_WR,   16'h00BB, 16'h0050, 16'd5, 5'd16, 1, 1, 0, 0, 0);
        add(OP_WR,   16'h0025, 16'h0000, 16'd3, 5'd16, 1, 0, 0, 0, 0);
        add(OP_WR,   16'h0000, 16'h0000, 16'd1, 5'd16, 1, 0, 0, 0, 0);
`ifdef KCH_REPLACE_EN
        add(OP_SCAN, 0, 0, 0, 5'd16, 1, 0, 1, 16'h00AA, 16'd1);
`else
        add(OP_SCAN, 0, 0, 0, 5'd16, 1, 0, 1, 16'h0025, 16'd3);
`endif

        // Reset values
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_found", 32'(found), 32'd0);
        chk("rst_ch", 32'(chosen_ch), 32'd0);
        chk("rst_hops", 32'(chosen_hops), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_ready", 32'(wr_ready), 32'd1);
        nrst = 1'b1;
        tick();

        last_ch = '0;
        last_hops = '0;
        foreach (vec_q[k]) begin
            if (vec_q[k].kind == OP_SCAN) begin
                do_scan(vec_q[k].exp_found, vec_q[k].exp_ch, vec_q[k].exp_hops, vec_q[k].exp_count);
                last_ch = vec_q[k].exp_ch;
                last_hops = vec_q[k].exp_hops;
            end else begin
                wr_en     = (vec_q[k].kind == OP_WR || vec_q[k].kind == OP_WRCLR);
                clear     = (vec_q[k].kind == OP_CLR || vec_q[k].kind == OP_WRCLR);
                wr_id     = vec_q[k].id;
                wr_qvalue = vec_q[k].q;
                wr_hops   = vec_q[k].hops;
                tick();
                wr_en = 1'b0;
                clear = 1'b0;
                chk($sformatf("v%0d_count", k), 32'(count), 32'(vec_q[k].exp_count));
                chk($sformatf("v%0d_full", k), 32'(full), 32'(vec_q[k].exp_full));
                chk($sformatf("v%0d_overflow", k), 32'(overflow), 32'(vec_q[k].exp_ovf));
            end
        end

        // Clear in the middle of a scan: abort without done, outputs held
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_full", 32'(full), 32'd0);
        saw_done = 0;
        if (done) saw_done = 1;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done) saw_done = 1;
        end
        chk("clr_no_done", 32'(saw_done), 32'd0);
        chk("clr_ch_hold", 32'(chosen_ch), 32'(last_ch));
        chk("clr_hops_hold", 32'(chosen_hops), 32'(last_hops));
        chk("clr_found_hold", 32'(found), 32'd1);

        // Writes during a scan are ignored
        wr_en = 1'b1; wr_id = 16'h0041; wr_qvalue = 16'h0010; wr_hops = 16'd2;
        tick();
        wr_id = 16'h0042; wr_hops = 16'd1;
        tick();
        wr_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("busy_ready", 32'(wr_ready), 32'd0);
        wr_en = 1'b1; wr_id = 16'h0077; wr_hops = 16'd0;
        tick();
        wr_en = 1'b0;
        chk("busy_write_count", 32'(count), 32'd2);
        saw_done = 0;
        for (int i = 0; i < 40 && !saw_done; i++) begin
            tick();
            if (done) saw_done = 1;
        end
        chk("busyw_done", 32'(saw_done), 32'd1);
        chk("busyw_ch", 32'(chosen_ch), 32'h0042);
        chk("busyw_hops", 32'(chosen_hops), 32'd1);
        chk("busyw_count", 32'(count), 32'd2);

        // Asynchronous reset in the middle of a scan
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        nrst = 1'b0;
        #1;
        chk("nrst_busy", 32'(busy), 32'd0);
        chk("nrst_count", 32'(count), 32'd0);
        chk("nrst_found", 32'(found), 32'd0);
        chk("nrst_ch", 32'(chosen_ch), 32'd0);
        tick();
        nrst = 1'b1;
        saw_done = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done) saw_done = 1;
        end
        chk("nrst_no_done", 32'(saw_done), 32'd0);
        chk("nrst_busy_after", 32'(busy), 32'd0);
        do_scan(1'b0, 16'h0000, 16'd0, 5'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cluster_head_selector.md
# cluster_head_selector

Parametrised cluster-head table and selector for the EER-RL node controller. Stores up to DEPTH advertised cluster heads (ID, Q-value, hop count) from received CH advertisements. On request, it runs a sequential scan and picks the entry with the fewest hops, breaking ties on the highest Q-value and then on the lowest slot index. The result feeds the join/route logic as the node's chosen CH and its hop distance.

## Interface
- DEPTH, 16: number of table slots (≥2)
- ID_W, 16: CH ID width; ID 0 is reserved as "empty"
- Q_W, 16: Q-value width, unsigned fixed point
- HOP_W, 16: hop-count width, unsigned

Ports:
- clk  input  1  system clock, rising edge
- nrst  input  1  asynchronous active-low reset
- wr_en  input  1  write/update request, one entry per cycle
- wr_id  input  ID_W  advertised CH ID
- wr_qvalue  input  Q_W  advertised Q-value
- wr_hops  input  HOP_W  advertised hop count
- wr_ready  output  1  high when writes are accepted (= !busy)
- clear  input  1  synchronous flush of all slots
- start  input  1  begin selection scan
- busy  output  1  scan in progress
- done  output  1  one-cycle pulse when scan completes
- found  output  1  a valid CH was selected (held)
- chosen_ch  output  ID_W  selected CH ID (held)
- chosen_hops  output  HOP_W  hop count of selected CH (held)
- count  output  $clog2(DEPTH+1)  number of occupied slots
- full  output  1  count == DEPTH
- overflow  output  1  one-cycle pulse when a new ID is dropped

## Operation
- Slot is occupied iff its stored ID ≠ 0.
- Write (wr_en && wr_ready && wr_id ≠ 0):
  - ID already present: overwrite that slot's Q-value and hops.
  - Otherwise, if not full: insert into the lowest-index free slot; count increments.
  - Otherwise, if full: drop and pulse overflow (see Configuration).
- wr_id == 0, or wr_en while busy: ignored; no state change.
- FSM states IDLE → SCAN → DONE → IDLE.
  - IDLE: start moves the FSM to SCAN with idx = 0 and best cleared.
  - SCAN: evaluates slot idx each cycle. The candidate replaces best if occupied and (no best yet, or hops < best_hops, or hops == best_hops and Q > best_Q). Equal hops and equal Q keep the earlier slot. After idx == DEPTH-1 the FSM moves to DONE.
  - DONE: loads chosen_ch, chosen_hops and found from best, pulses done, and returns to IDLE.
- Empty table: found = 0, chosen_ch = 0, chosen_hops = 0.
- clear: all IDs are zeroed and count becomes 0. If busy, the scan is aborted: no done pulse, and outputs keep their previous values.
- clear and wr_en in the same cycle: clear wins and the write is discarded.
- start while busy: ignored.

## Timing
- All outputs reset to 0: busy, done, found, chosen_ch, chosen_hops, count, full, overflow. Reset also empties every slot and returns the FSM to IDLE.
- Write accepted at edge N is visible in count/full after edge N and is included in any scan started at edge N+1 or later.
- start sampled at edge T: busy is high from T+1 through T+DEPTH+1. done and the updated outputs appear after edge T+DEPTH+1, giving a latency of DEPTH+1 cycles.
- chosen_ch, chosen_hops and found hold until the next completed scan or reset.
- overflow is registered and pulses the cycle after the rejected write.

## Configuration
- KCH_REPLACE_EN defined:
  - A new ID arriving while full replaces the occupied slot with the largest hop count, but only if the new hop count is strictly smaller. Ties between candidate slots go to the lowest index.
  - No overflow pulse on replacement. overflow pulses only when nothing is replaced.
- KCH_REPLACE_EN undefined: a new ID arriving while full is always dropped and overflow pulses.

## Test plan
- Reset, then write (ID 0x0001, Q 0x00C0, hops 2), (0x0002, 0x00F0, 3), (0x0003, 0x00E6, 2), then start → done after 17 cycles, chosen_ch = 0x0003, chosen_hops = 2, found = 1, count = 3.
- Write ID 0x0005 twice, first with hops 4 and then with hops 1, then scan → count = 1, chosen_hops = 1.
- Two entries with identical hops 2 and Q 0x0080 in slots 0 and 1 → chosen_ch is the slot-0 ID.
- Scan on empty table → done pulse, found = 0, chosen_ch = 0.
- Fill 16 slots with hops 5, then write new ID 0x00AA with hops 1 → without macro: overflow pulse, count = 16. With KCH_REPLACE_EN: slot 0 is overwritten, a scan selects 0x00AA, and no overflow pulse.
- Assert clear mid-scan, and assert nrst low mid-scan → no done pulse, busy low the next cycle (clear) or immediately (nrst), count = 0.
